// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared constants for the RS232 receive path: FSM state
//                encodings and the default bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

    // Receiver FSM state encodings
    localparam logic [2:0] c_state_idle  = 3'd0;
    localparam logic [2:0] c_state_start = 3'd1;
    localparam logic [2:0] c_state_data  = 3'd2;
    localparam logic [2:0] c_state_stop  = 3'd3;
    localparam logic [2:0] c_state_break = 3'd4;

    // clk cycles per bit at 50 MHz / 115200 baud
    localparam int unsigned c_baud_div_default = 434;

endpackage : rs232_pkg
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sync
//  Description : SYNC_STAGES-deep flip-flop synchronizer for the serial line.
//                Resets to 1 so a reset never looks like a start bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rxs_o
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw line through the chain; reset to idle-high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs_o = r_sync[SYNC_STAGES-1];

endmodule : rx_sync
`default_nettype wire

// File: rtl/rs232_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_rx_fsm
//  Description : RS232 receive front end. Synchronizes rx_i, detects the
//                start bit, samples data bits at mid-bit (LSB first) and
//                reports each frame as a valid strobe or a framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx_fsm
    import rs232_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = c_baud_div_default,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic                 en_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 ferr_o,
    output logic                 busy_o
);

    localparam int unsigned c_half_div = BAUD_DIV / 2;
    localparam int unsigned c_cnt_w    = $clog2(BAUD_DIV);
    localparam int unsigned c_bit_w    = $clog2(DATA_BITS + 1);

    // Terminal counts: mid start bit, full bit period, last data bit
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_div - 1);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bits_last = c_bit_w'(DATA_BITS - 1);

    logic                 w_rxs;
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
    logic                 w_sample;
    logic                 w_last_bit;
    logic                 w_valid_next;
    logic                 w_ferr_next;

    rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .rxs_o (w_rxs)
    );

    // Sample strobe: half a bit into START, a full bit in DATA and STOP
    always_comb begin
        w_sample = 1'b0;
        case (r_state)
            c_state_start: w_sample = (r_baud_cnt == c_half_last);
            c_state_data,
            c_state_stop:  w_sample = (r_baud_cnt == c_baud_last);
            default:       w_sample = 1'b0;
        endcase
    end

    assign w_last_bit = (r_bit_cnt == c_bits_last);

    // Next-state and output-strobe decode; disable aborts from any state
    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        if (!en_i) begin
            w_state_next = c_state_idle;
        end else begin
            case (r_state)
                c_state_idle: begin
                    if (!w_rxs) w_state_next = c_state_start;
                end
                c_state_start: begin
                    if (w_sample) w_state_next = w_rxs ? c_state_idle : c_state_data;
                end
                c_state_data: begin
                    if (w_sample && w_last_bit) w_state_next = c_state_stop;
                end
                c_state_stop: begin
                    if (w_sample) begin
                        if (w_rxs) begin
                            w_valid_next = 1'b1;
                            w_state_next = c_state_idle;
                        end else begin
                            w_ferr_next  = 1'b1;
                            w_state_next = c_state_break;
                        end
                    end
                end
                c_state_break: begin
                    if (w_rxs) w_state_next = c_state_idle;
                end
                default: w_state_next = c_state_idle;
            endcase
        end
    end

    // State register plus registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_state_idle;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
            r_busy  <= (w_state_next != c_state_idle);
            if (w_valid_next) r_data <= r_shift;
        end
    end

    // Baud counter restarts on every state entry and after every sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_baud_cnt <= '0;
        end else if ((w_state_next != r_state) || w_sample) begin
            r_baud_cnt <= '0;
        end else if ((r_state == c_state_start) || (r_state == c_state_data) ||
                     (r_state == c_state_stop)) begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end else begin
            r_baud_cnt <= '0;
        end
    end

    // Bit counter and LSB-first shift register, advanced on DATA samples
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (r_state != c_state_data) begin
            r_bit_cnt <= '0;
        end else if (w_sample && en_i) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign ferr_o  = r_ferr;
    assign busy_o  = r_busy;

endmodule : rs232_rx_fsm
`default_nettype wire
